// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC generator: one outstanding instruction read, a one-entry
// decode buffer, and squashing of wrong-path fetches on jump/trap redirects.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_pc_in,
    input  logic [31:0] jump_target_in,
    input  logic        trap_valid_in,
    input  logic [31:0] trap_pc_in,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    input  logic        fetch_ready
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] inst_q_r;
    logic [31:0] pc_q_r;
    logic [31:0] sel_pc_s;
    logic [31:0] target_s;
    logic        drop_r;
    logic        drop_nxt_s;
    logic        redirect_s;
    logic        capture_s;
    logic        fetch_hs_s;

    // Trap outranks jump; targets are always word aligned.
    assign redirect_s    = trap_valid_in | jump_pc_in;
    assign sel_pc_s      = trap_valid_in ? trap_pc_in : jump_target_in;
    assign target_s      = sel_pc_s & 32'hFFFF_FFFC;

    // Request depends only on state, never on mem_req_ready.
    assign mem_req_valid = (state_r == ST_REQ) && !reset;
    assign mem_req_addr  = pc_r;
    // Combinational squash keeps a wrong-path instruction from leaving in the redirect cycle.
    assign fetch_valid   = (state_r == ST_HOLD) && !redirect_s && !reset;
    assign fetch_hs_s    = fetch_valid && fetch_ready;
    assign fetch_inst    = inst_q_r;
    assign fetch_pc      = pc_q_r;

    // Next-state, drop-flag and capture decisions of the fetch FSM.
    always_comb begin
        state_nxt_s = state_r;
        drop_nxt_s  = drop_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_nxt_s = ST_WAIT;
                    drop_nxt_s  = redirect_s;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    drop_nxt_s = 1'b0;
                    if (drop_r || redirect_s) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_HOLD;
                        capture_s   = 1'b1;
                    end
                end else if (redirect_s) begin
                    drop_nxt_s = 1'b1;
                end else begin
                    drop_nxt_s = drop_r;
                end
            end
            ST_HOLD: begin
                if (redirect_s || fetch_hs_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
                drop_nxt_s  = 1'b0;
            end
        endcase
    end

    // Next fetch PC: redirect target, sequential advance, or hold.
    always_comb begin
        pc_nxt_s = pc_r;
        if (redirect_s) begin
            pc_nxt_s = target_s;
        end else if (fetch_hs_s) begin
            pc_nxt_s = pc_r + 32'd4;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // State, PC and decode-buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_REQ;
            pc_r     <= RESET_PC;
            drop_r   <= 1'b0;
            inst_q_r <= 32'd0;
            pc_q_r   <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            drop_r  <= drop_nxt_s;
            if (capture_s) begin
                inst_q_r <= mem_resp_data;
                pc_q_r   <= pc_r;
            end else begin
                inst_q_r <= inst_q_r;
                pc_q_r   <= pc_q_r;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed cycle table for corner cases, then a
// randomised memory/decode run checked against a scoreboard of expected fetches.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        jump_pc_in;
    logic [31:0] jump_target_in;
    logic        trap_valid_in;
    logic [31:0] trap_pc_in;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic        fetch_ready;

    fetch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset),
        .jump_pc_in(jump_pc_in), .jump_target_in(jump_target_in),
        .trap_valid_in(trap_valid_in), .trap_pc_in(trap_pc_in),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .fetch_valid(fetch_valid),
        .fetch_inst(fetch_inst), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        fr;
        logic        jmp;
        logic [31:0] jt;
        logic        trp;
        logic [31:0] tp;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_fv;
        logic [31:0] e_fi;
        logic [31:0] e_fp;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } fexp_t;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t  vecs[$];
    fexp_t fq[$];

    localparam logic [31:0] Z = 32'h0;

    function automatic vec_t mk(logic rst, logic rdy, logic rv, logic [31:0] rd, logic fr,
                                logic jmp, logic [31:0] jt, logic trp, logic [31:0] tp,
                                logic e_rv, logic [31:0] e_ra, logic e_fv,
                                logic [31:0] e_fi, logic [31:0] e_fp);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rd = rd; v.fr = fr;
        v.jmp = jmp; v.jt = jt; v.trp = trp; v.tp = tp;
        v.e_rv = e_rv; v.e_ra = e_ra; v.e_fv = e_fv; v.e_fi = e_fi; v.e_fp = e_fp;
        return v;
    endfunction

    function automatic logic [31:0] memf(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        reset          = v.rst;
        mem_req_ready  = v.rdy;
        mem_resp_valid = v.rv;
        mem_resp_data  = v.rd;
        fetch_ready    = v.fr;
        jump_pc_in     = v.jmp;
        jump_target_in = v.jt;
        trap_valid_in  = v.trp;
        trap_pc_in     = v.tp;
    endtask

    initial begin
        vec_t v;
        logic [31:0] exp_addr;
        fexp_t fe;
        int pend;
        int lat;
        int handoffs;
        logic acc;

        drive(mk(1'b1, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, Z, 1'b0, Z, Z));

        // reset, then back-to-back fetches every 3 cycles
        vecs.push_back(mk(1,0,0,Z,0,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(1,0,0,Z,0,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'h100,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'h13,0,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,1,0,Z,0,Z, 0,Z,1,32'h13,32'h100));
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'h104,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'h13,0,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,1,0,Z,0,Z, 0,Z,1,32'h13,32'h104));
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'h108,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'h13,0,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,1,0,Z,0,Z, 0,Z,1,32'h13,32'h108));
        // backpressure: 5 stalled HOLD cycles
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'h10C,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'hAABBCCDD,0,0,Z,0,Z, 0,Z,0,Z,Z));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0,Z,0,0,Z,0,Z, 0,Z,1,32'hAABBCCDD,32'h10C));
        vecs.push_back(mk(0,0,0,Z,1,0,Z,0,Z, 0,Z,1,32'hAABBCCDD,32'h10C));
        vecs.push_back(mk(0,0,0,Z,0,0,Z,0,Z, 1,32'h110,0,Z,Z));
        // redirect while the response is outstanding
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'h110,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,0,1,32'h2003,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,0,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'hDEADBEEF,1,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,0,0,Z,0,Z, 1,32'h2000,0,Z,Z));
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'h2000,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'h11111111,0,0,Z,0,Z, 0,Z,0,Z,Z));
        // redirect in HOLD together with fetch_ready
        vecs.push_back(mk(0,0,0,Z,1,1,32'h400,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,0,0,Z,0,Z, 1,32'h400,0,Z,Z));
        // trap and jump together in REQ
        vecs.push_back(mk(0,0,0,Z,0,1,32'h500,1,32'h80, 1,32'h400,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,0,0,Z,0,Z, 1,32'h80,0,Z,Z));
        // redirect in the same cycle the request is accepted
        vecs.push_back(mk(0,1,0,Z,0,1,32'h604,0,Z, 1,32'h80,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'h22222222,0,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'h604,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'h33333333,0,0,Z,0,Z, 0,Z,0,Z,Z));
        // unaligned redirect in HOLD to the top word, then wrap
        vecs.push_back(mk(0,0,0,Z,0,1,32'hFFFFFFFF,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'hFFFFFFFC,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'h44444444,0,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,1,0,Z,0,Z, 0,Z,1,32'h44444444,32'hFFFFFFFC));
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'h0,0,Z,Z));
        // reset during WAIT; the following response must be kept (drop clear)
        vecs.push_back(mk(1,0,0,Z,0,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,0,0,Z,0,Z, 1,32'h100,0,Z,Z));
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'h100,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'h55555555,0,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,1,0,Z,0,Z, 0,Z,1,32'h55555555,32'h100));
        // stray response in REQ is ignored
        vecs.push_back(mk(0,0,1,32'h66,0,0,Z,0,Z, 1,32'h104,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,0,0,Z,0,Z, 1,32'h104,0,Z,Z));
        // second redirect while drop already set: only the PC moves
        vecs.push_back(mk(0,1,0,Z,0,0,Z,0,Z, 1,32'h104,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,0,1,32'h700,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,0,1,32'h800,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,1,32'h99,1,0,Z,0,Z, 0,Z,0,Z,Z));
        vecs.push_back(mk(0,0,0,Z,0,0,Z,0,Z, 1,32'h800,0,Z,Z));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d req_valid", i), {31'd0, mem_req_valid}, {31'd0, vecs[i].e_rv});
            if (vecs[i].e_rv) chk($sformatf("v%0d req_addr", i), mem_req_addr, vecs[i].e_ra);
            chk($sformatf("v%0d fetch_valid", i), {31'd0, fetch_valid}, {31'd0, vecs[i].e_fv});
            if (vecs[i].e_fv) begin
                chk($sformatf("v%0d fetch_inst", i), fetch_inst, vecs[i].e_fi);
                chk($sformatf("v%0d fetch_pc", i), fetch_pc, vecs[i].e_fp);
            end
        end

        // randomised run: bench memory model plus scoreboard of expected fetches
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(mk(1,0,0,Z,0,0,Z,0,Z, 0,Z,0,Z,Z));
            #1;
            chk("rand reset req_valid", {31'd0, mem_req_valid}, 32'd0);
        end
        exp_addr = 32'h100;
        pend     = 0;
        lat      = 0;
        handoffs = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            v = mk(0,0,0,Z,0,0,Z,0,Z, 0,Z,0,Z,Z);
            v.rdy = ($urandom_range(0, 1) == 1);
            v.fr  = ($urandom_range(0, 3) != 0);
            if (pend != 0 && lat == 0) begin
                v.rv = 1'b1;
                v.rd = memf(fq[fq.size()-1].pc);
            end else if (pend == 0 && $urandom_range(0, 7) == 0) begin
                v.rv = 1'b1;
                v.rd = 32'hBAD0_0000;
            end
            drive(v);
            #1;
            acc = 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                chk("rand req_addr", mem_req_addr, exp_addr);
                fe.pc   = exp_addr;
                fe.inst = memf(exp_addr);
                fq.push_back(fe);
                pend = 1;
                lat  = $urandom_range(0, 2);
                acc  = 1'b1;
            end
            if (fetch_valid && fetch_ready) begin
                if (fq.size() == 0) begin
                    chk("rand unexpected fetch", fetch_pc, 32'hFFFF_FFFF);
                end else begin
                    fe = fq.pop_front();
                    chk("rand fetch_pc", fetch_pc, fe.pc);
                    chk("rand fetch_inst", fetch_inst, fe.inst);
                end
                exp_addr = exp_addr + 32'd4;
                handoffs++;
            end
            if (!acc && pend != 0) begin
                if (lat == 0) pend = 0;
                else lat--;
            end
        end
        chk("rand handoffs>=20", {31'd0, (handoffs >= 20)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
